// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier.
package mult_pkg;

    localparam int MULT_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder built from per-bit full-adder cells.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier (one multiplier bit per CALC cycle).
// Optional SHIFT_ADD_MULT_EARLY_EXIT_EN: stop once the remaining multiplier bits are zero.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mult_state_e         state;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    mq;
    logic [CNT_W-1:0]    cnt;

    logic [WIDTH-1:0]    addend;
    logic [WIDTH-1:0]    sum;
    logic                carry;
    logic [2*WIDTH:0]    cat;
    logic [2*WIDTH-1:0]  shifted;
    logic [2*WIDTH-1:0]  next_am;
    logic                exit_now;

    assign addend = mq[0] ? a_reg : '0;

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    // Carry-out enters at the top so the full (C,ACC,MQ) word shifts as one.
    assign cat     = {carry, sum, mq};
    assign shifted = cat[2*WIDTH:1];

`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    logic [CNT_W-1:0]    remain;
    logic [WIDTH-2:0]    rem_mask;

    assign remain = LAST - cnt;

    always_comb begin
        rem_mask = '0;
        for (int j = 0; j < WIDTH - 1; j++) begin
            rem_mask[j] = (j < int'(remain));
        end
    end

    // Unprocessed multiplier bits sit in mq[remain:1]; zeros there only shift.
    assign exit_now = (cnt == LAST) || ((mq[WIDTH-1:1] & rem_mask) == '0);
    assign next_am  = exit_now ? (shifted >> remain) : shifted;
`else
    assign exit_now = (cnt == LAST);
    assign next_am  = shifted;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            acc     <= '0;
            mq      <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        mq    <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    {acc, mq} <= next_am;
                    cnt       <= cnt + 1'b1;
                    if (exit_now) begin
                        product <= next_am;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
